sram_like_arbiter_nx1: RTL

SRAM_LIKE_ARBITER_NX1 -- requirements
Module: sram_like_arbiter_nx1

---
 rtl/sram_like_arbiter_nx1_pkg.sv | 21 ++
 rtl/sync_fifo_idx.sv | 55 +++++
 rtl/sram_like_arbiter_nx1.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sram_like_arbiter_nx1_pkg.sv
// Shared SRAM-like bus definitions: size encodings, legal parameter ranges and
// the arbiter lock states.
package sram_like_arbiter_nx1_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sram_size_e;

  localparam int unsigned NUM_PORTS_MIN = 2;
  localparam int unsigned NUM_PORTS_MAX = 8;
  localparam int unsigned MAX_OUT_MIN   = 2;
  localparam int unsigned MAX_OUT_MAX   = 16;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/sync_fifo_idx.sv
// Small synchronous FIFO of master indices used to route in-order responses.
module sync_fifo_idx #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  // Pointers rely on DEPTH being a power of two to wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter_nx1.sv
// N-to-1 round-robin arbiter for SRAM-like masters onto one in-order slave,
// with grant lock during stalled handshakes and FIFO-based response routing.
module sram_like_arbiter_nx1
  import sram_like_arbiter_nx1_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 3,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_PORTS-1:0]              m_req,
  input  logic [NUM_PORTS-1:0]              m_wr,
  input  logic [2*NUM_PORTS-1:0]            m_size,
  input  logic [32*NUM_PORTS-1:0]           m_addr,
  input  logic [32*NUM_PORTS-1:0]           m_wdata,
  output logic [NUM_PORTS-1:0]              m_addr_ok,
  output logic [NUM_PORTS-1:0]              m_data_ok,
  output logic [31:0]                       m_rdata,
  output logic                              s_req,
  output logic                              s_wr,
  output logic [1:0]                        s_size,
  output logic [31:0]                       s_addr,
  output logic [31:0]                       s_wdata,
  input  logic [31:0]                       s_rdata,
  input  logic                              s_addr_ok,
  input  logic                              s_data_ok,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              err_spurious
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  if (NUM_PORTS < NUM_PORTS_MIN || NUM_PORTS > NUM_PORTS_MAX ||
      MAX_OUTSTANDING < MAX_OUT_MIN || MAX_OUTSTANDING > MAX_OUT_MAX ||
      (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_cfg
    $error("sram_like_arbiter_nx1: illegal NUM_PORTS or MAX_OUTSTANDING");
  end

  lock_state_e      r_lock_state;
  lock_state_e      w_lock_next;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_lock_idx;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_rr_grant;
  logic [IDX_W-1:0] w_grant;
  logic [IDX_W-1:0] w_head;
  logic             w_rr_found;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_accept;
  logic             w_stall;
  logic             w_pop;
  logic             r_err_spurious;

  always_comb begin
    w_cand     = '0;
    w_rr_grant = r_rr_ptr;
    w_rr_found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_cand = IDX_W'((32'(r_rr_ptr) + i) % NUM_PORTS);
      if (!w_rr_found && m_req[w_cand]) begin
        w_rr_grant = w_cand;
        w_rr_found = 1'b1;
      end
    end
  end

  // In reset the request fields come from master 0 regardless of m_req.
  assign w_grant  = !aresetn ? '0 :
                    (r_lock_state == ST_LOCKED) ? r_lock_idx : w_rr_grant;

  assign s_req    = aresetn & (|m_req) & ~w_fifo_full;
  assign w_accept = s_req & s_addr_ok;
  assign w_stall  = s_req & ~s_addr_ok;
  assign w_pop    = aresetn & s_data_ok & ~w_fifo_empty;

  assign s_wr      = m_wr[w_grant];
  assign s_size    = m_size[w_grant*2 +: 2];
  assign s_addr    = m_addr[w_grant*32 +: 32];
  assign s_wdata   = m_wdata[w_grant*32 +: 32];
  assign m_addr_ok = w_accept ? (NUM_PORTS'(1) << w_grant) : '0;
  assign m_data_ok = w_pop ? (NUM_PORTS'(1) << w_head) : '0;
  assign m_rdata   = s_rdata;
  assign err_spurious = r_err_spurious;

  always_comb begin
    w_lock_next = r_lock_state;
    if (w_accept)     w_lock_next = ST_OPEN;
    else if (w_stall) w_lock_next = ST_LOCKED;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_lock_state   <= ST_OPEN;
      r_lock_idx     <= '0;
      r_rr_ptr       <= '0;
      r_err_spurious <= 1'b0;
    end else begin
      r_lock_state <= w_lock_next;
      if (w_stall) r_lock_idx <= w_grant;
      if (w_accept)
        r_rr_ptr <= (w_grant == IDX_W'(NUM_PORTS - 1)) ? '0 : w_grant + 1'b1;
      if (s_data_ok && w_fifo_empty) r_err_spurious <= 1'b1;
    end
  end

  sync_fifo_idx #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_route_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (w_accept),
    .din   (w_grant),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (outstanding)
  );

endmodule
